reg_writeback_queue: RTL and testbench
======================================

REG_WRITEBACK_QUEUE -- requirements
Module: reg_writeback_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register index width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning pending-write queue entries; power of two, at least 2.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  producer offers a write.
REQ-007 SHALL have port in_ready  output  1  queue can accept a write.
REQ-008 SHALL have port in_dest  input  ADDR_W  destination register index.
REQ-009 SHALL have port in_data  input  XLEN  write data.
REQ-010 SHALL have port rf_ready  input  1  register file accepts the offered write this cycle.
REQ-011 SHALL have port write_enable  output  1  write offered to the register file.
REQ-012 SHALL have port dest  output  ADDR_W  register file write index.
REQ-013 SHALL have port data_out  output  XLEN  register file write data.
REQ-014 SHALL have port src_one  input  ADDR_W  read index, port one.
REQ-015 SHALL have port src_two  input  ADDR_W  read index, port two.
REQ-016 SHALL have ports rf_one and rf_two  input  XLEN  raw register file read data.
REQ-017 SHALL have ports out_one and out_two  output  XLEN  resolved read data.
REQ-018 SHALL have ports hazard_one and hazard_two  output  1  read index matches an undrained write.
REQ-019 SHALL have port count  output  $clog2(DEPTH)+1  pending entries.

Function
REQ-020 SHALL hold writes in an in-order circular FIFO of DEPTH entries {dest, data} with wrapping head and tail pointers.
REQ-021 SHALL drive in_ready = (count != DEPTH), combinationally.
REQ-022 SHALL accept a write when in_valid && in_ready on a rising edge; an accepted write with in_dest == 0 SHALL be discarded, not enqueued.
REQ-023 SHALL drive write_enable = (count != 0), with dest and data_out taken from the head entry; an entry enqueued at edge N SHALL appear at the head no earlier than cycle N+1.
REQ-024 SHALL pop the head when write_enable && rf_ready; write_enable, dest and data_out SHALL hold stable while rf_ready is low.
REQ-025 SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers; when full, in_ready SHALL stay low in the pop cycle (no same-cycle pass-through).
REQ-026 SHALL never match an index of 0 as a pending entry.
REQ-027 SHALL keep drain order equal to accept order, including writes to the same index.

Reset
REQ-028 SHALL, while reset is low at a rising edge, clear head, tail and count, discard all pending entries, and give write_enable=0, in_ready=1, hazard_one=hazard_two=0.
REQ-029 SHALL give reset priority over simultaneous push and pop; no write issued in that cycle SHALL be retained.

Configuration
REQ-030 SHALL, with macro WB_BYPASS_EN defined, drive out_one from the youngest pending entry whose dest equals src_one, else from rf_one; out_two SHALL follow the same rule using src_two and rf_two; hazard_one and hazard_two SHALL be 0.
REQ-031 SHALL, without WB_BYPASS_EN, pass out_one=rf_one and out_two=rf_two, and assert hazard_one (resp. hazard_two) while any pending entry's dest equals src_one (resp. src_two).

Verification
REQ-032 Scenario: push (3,0xA5) with rf_ready=1 -> next cycle write_enable=1, dest=3, data_out=0xA5; the following cycle count=0.
REQ-033 Scenario: rf_ready=0, push 4 distinct writes -> count=4, in_ready=0; 5th offer not accepted; rf_ready=1 -> drains in order over 4 cycles.
REQ-034 Scenario: push (0,0xFFFF) -> in_ready=1 during offer, count stays 0, write_enable stays 0.
REQ-035 Scenario: WB_BYPASS_EN, rf_ready=0, push (7,0x11) then (7,0x22), src_one=7, rf_one=0x99 -> out_one=0x22; without macro -> out_one=0x99, hazard_one=1.
REQ-036 Scenario: full queue, rf_ready=1 and in_valid=1 for 6 cycles -> pointers wrap, every accepted write drains exactly once, in order.
REQ-037 Scenario: reset low with count=3 -> next cycle count=0, write_enable=0, in_ready=1.

Source files
------------

// File: rtl/reg_writeback_queue.sv
// In-order register write-back queue with read-port hazard detection.
// Optional macro WB_BYPASS_EN forwards the youngest pending write to the read ports instead of flagging a hazard.
module reg_writeback_queue #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_dest,
    input  logic [XLEN-1:0]            in_data,
    input  logic                       rf_ready,
    output logic                       write_enable,
    output logic [ADDR_W-1:0]          dest,
    output logic [XLEN-1:0]            data_out,
    input  logic [ADDR_W-1:0]          src_one,
    input  logic [ADDR_W-1:0]          src_two,
    input  logic [XLEN-1:0]            rf_one,
    input  logic [XLEN-1:0]            rf_two,
    output logic [XLEN-1:0]            out_one,
    output logic [XLEN-1:0]            out_two,
    output logic                       hazard_one,
    output logic                       hazard_two,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1'b1);
    localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    logic [ADDR_W-1:0] dest_mem_r [DEPTH];
    logic [XLEN-1:0]   data_mem_r [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic              push_s;
    logic              pop_s;
    logic [PTR_W-1:0]  slot_s;

    // Writes to register 0 are accepted handshake-wise but never stored.
    assign in_ready     = (count_r != FULL_CNT);
    assign push_s       = in_valid && in_ready && (in_dest != ADDR_ZERO);
    assign write_enable = (count_r != CNT_ZERO);
    assign pop_s        = write_enable && rf_ready;
    assign dest         = dest_mem_r[head_r];
    assign data_out     = data_mem_r[head_r];
    assign count        = count_r;

    // Entry storage; stale slots are harmless because only count_r marks them live.
    always_ff @(posedge clk) begin
        if (push_s) begin
            dest_mem_r[tail_r] <= in_dest;
            data_mem_r[tail_r] <= in_data;
        end
    end

    // Pointer and occupancy state with synchronous active-low reset taking priority.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_r  <= PTR_ZERO;
            tail_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef WB_BYPASS_EN
    logic [XLEN-1:0] byp_one_s;
    logic [XLEN-1:0] byp_two_s;

    // Walk oldest to youngest so the last match is the youngest pending write.
    always_comb begin
        byp_one_s = rf_one;
        byp_two_s = rf_two;
        slot_s    = head_r;
        for (int i = 0; i < DEPTH; i++) begin
            slot_s = head_r + PTR_W'(i);
            if ((CNT_W'(i) < count_r) && (src_one != ADDR_ZERO) && (dest_mem_r[slot_s] == src_one)) begin
                byp_one_s = data_mem_r[slot_s];
            end else begin
                byp_one_s = byp_one_s;
            end
            if ((CNT_W'(i) < count_r) && (src_two != ADDR_ZERO) && (dest_mem_r[slot_s] == src_two)) begin
                byp_two_s = data_mem_r[slot_s];
            end else begin
                byp_two_s = byp_two_s;
            end
        end
    end

    assign out_one    = byp_one_s;
    assign out_two    = byp_two_s;
    assign hazard_one = 1'b0;
    assign hazard_two = 1'b0;
`else
    logic hit_one_s;
    logic hit_two_s;

    // Flag a hazard when any live entry targets a read index.
    always_comb begin
        hit_one_s = 1'b0;
        hit_two_s = 1'b0;
        slot_s    = head_r;
        for (int i = 0; i < DEPTH; i++) begin
            slot_s = head_r + PTR_W'(i);
            if ((CNT_W'(i) < count_r) && (src_one != ADDR_ZERO) && (dest_mem_r[slot_s] == src_one)) begin
                hit_one_s = 1'b1;
            end else begin
                hit_one_s = hit_one_s;
            end
            if ((CNT_W'(i) < count_r) && (src_two != ADDR_ZERO) && (dest_mem_r[slot_s] == src_two)) begin
                hit_two_s = 1'b1;
            end else begin
                hit_two_s = hit_two_s;
            end
        end
    end

    assign out_one    = rf_one;
    assign out_two    = rf_two;
    assign hazard_one = hit_one_s;
    assign hazard_two = hit_two_s;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Scoreboard bench for reg_writeback_queue: a reference model predicts accepted writes,
// a negedge monitor compares every drained write and the read-port resolution.
module tb_reg_writeback_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_dest;
    logic [31:0] in_data;
    logic        rf_ready;
    logic        write_enable;
    logic [4:0]  dest;
    logic [31:0] data_out;
    logic [4:0]  src_one;
    logic [4:0]  src_two;
    logic [31:0] rf_one;
    logic [31:0] rf_two;
    logic [31:0] out_one;
    logic [31:0] out_two;
    logic        hazard_one;
    logic        hazard_two;
    logic [2:0]  count;

    typedef struct {
        logic [4:0]  d;
        logic [31:0] v;
    } ent_t;

    ent_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   mcnt   = 0;
    int   drains = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    reg_writeback_queue #(.XLEN(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest), .in_data(in_data),
        .rf_ready(rf_ready), .write_enable(write_enable), .dest(dest), .data_out(data_out),
        .src_one(src_one), .src_two(src_two), .rf_one(rf_one), .rf_two(rf_two),
        .out_one(out_one), .out_two(out_two), .hazard_one(hazard_one), .hazard_two(hazard_two),
        .count(count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: predicts acceptance and occupancy from the bench's own inputs.
    always @(posedge clk) begin
        bit acc;
        bit pop;
        if (!reset) begin
            mcnt = 0;
            exp_q.delete();
        end else begin
            acc = in_valid && (mcnt != DEPTH) && (in_dest != 5'd0);
            pop = (mcnt != 0) && rf_ready;
            if (acc) begin
                ent_t e;
                e.d = in_dest;
                e.v = in_data;
                exp_q.push_back(e);
            end
            mcnt = mcnt + (acc ? 1 : 0) - (pop ? 1 : 0);
        end
    end

    // Monitor: compare status, read-port resolution, and every drained write.
    always @(negedge clk) begin
        if (mon_en) begin
            bit          h1;
            bit          h2;
            logic [31:0] o1;
            logic [31:0] o2;
            h1 = 1'b0; h2 = 1'b0; o1 = rf_one; o2 = rf_two;
            foreach (exp_q[k]) begin
                if (src_one != 5'd0 && exp_q[k].d == src_one) begin h1 = 1'b1; o1 = exp_q[k].v; end
                if (src_two != 5'd0 && exp_q[k].d == src_two) begin h2 = 1'b1; o2 = exp_q[k].v; end
            end
            check("mon_count", {29'd0, count}, mcnt);
            check("mon_in_ready", {31'd0, in_ready}, {31'd0, (mcnt != DEPTH)});
            check("mon_write_enable", {31'd0, write_enable}, {31'd0, (mcnt != 0)});
`ifdef WB_BYPASS_EN
            check("mon_out_one", out_one, o1);
            check("mon_out_two", out_two, o2);
            check("mon_hazard_one", {31'd0, hazard_one}, 32'd0);
            check("mon_hazard_two", {31'd0, hazard_two}, 32'd0);
`else
            check("mon_out_one", out_one, rf_one);
            check("mon_out_two", out_two, rf_two);
            check("mon_hazard_one", {31'd0, hazard_one}, {31'd0, h1});
            check("mon_hazard_two", {31'd0, hazard_two}, {31'd0, h2});
`endif
            if (reset && write_enable && rf_ready) begin
                if (exp_q.size() == 0) begin
                    check("drain_unexpected", {31'd0, write_enable}, 32'd0);
                end else begin
                    ent_t e;
                    e = exp_q.pop_front();
                    check("drain_dest", {27'd0, dest}, {27'd0, e.d});
                    check("drain_data", data_out, e.v);
                    drains++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [4:0] d, input logic [31:0] v);
        in_valid = 1'b1;
        in_dest  = d;
        in_data  = v;
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_dest = 5'd0; in_data = 32'd0; rf_ready = 1'b0;
        src_one = 5'd0; src_two = 5'd0; rf_one = 32'h99; rf_two = 32'h77;
        cyc(); cyc();
        @(negedge clk);
        check("reset_count", {29'd0, count}, 32'd0);
        check("reset_we", {31'd0, write_enable}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_hazards", {30'd0, hazard_one, hazard_two}, 32'd0);
        cyc();
        reset  = 1'b1;
        mon_en = 1'b1;

        // single write with the register file ready
        rf_ready = 1'b1;
        offer(5'd3, 32'hA5);
        @(negedge clk);
        check("s1_we", {31'd0, write_enable}, 32'd1);
        check("s1_dest", {27'd0, dest}, 32'd3);
        check("s1_data", data_out, 32'hA5);
        cyc();
        @(negedge clk);
        check("s1_count_after", {29'd0, count}, 32'd0);

        // fill, reject a fifth offer, then drain in order
        rf_ready = 1'b0; src_one = 5'd2; src_two = 5'd5;
        offer(5'd1, 32'h101); offer(5'd2, 32'h202); offer(5'd4, 32'h404); offer(5'd5, 32'h505);
        @(negedge clk);
        check("s2_count_full", {29'd0, count}, 32'd4);
        check("s2_in_ready_full", {31'd0, in_ready}, 32'd0);
`ifndef WB_BYPASS_EN
        check("s2_hazard_one", {31'd0, hazard_one}, 32'd1);
`endif
        offer(5'd6, 32'h606);
        @(negedge clk);
        check("s2_count_after_reject", {29'd0, count}, 32'd4);
        rf_ready = 1'b1;
        repeat (4) cyc();
        @(negedge clk);
        check("s2_count_drained", {29'd0, count}, 32'd0);
        src_one = 5'd0; src_two = 5'd0;

        // write to register 0 is discarded
        in_valid = 1'b1; in_dest = 5'd0; in_data = 32'hFFFF;
        @(negedge clk);
        check("s3_in_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        check("s3_count", {29'd0, count}, 32'd0);
        check("s3_we", {31'd0, write_enable}, 32'd0);

        // two writes to the same index, read port resolution
        rf_ready = 1'b0; src_one = 5'd7; rf_one = 32'h99;
        offer(5'd7, 32'h11); offer(5'd7, 32'h22);
        @(negedge clk);
`ifdef WB_BYPASS_EN
        check("s4_out_one", out_one, 32'h22);
        check("s4_hazard_one", {31'd0, hazard_one}, 32'd0);
`else
        check("s4_out_one", out_one, 32'h99);
        check("s4_hazard_one", {31'd0, hazard_one}, 32'd1);
`endif
        rf_ready = 1'b1;
        cyc(); cyc();
        src_one = 5'd0;

        // full queue under continuous push and pop: pointers wrap
        rf_ready = 1'b0; src_two = 5'd17;
        offer(5'd8, 32'h800); offer(5'd9, 32'h900); offer(5'd10, 32'hA00); offer(5'd11, 32'hB00);
        @(negedge clk);
        check("s5_count_full", {29'd0, count}, 32'd4);
        rf_ready = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_dest = 5'(12 + k);
            in_data = 32'hC00 + 32'(k);
            cyc();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("s5_count_steady", {29'd0, count}, 32'd3);
        repeat (4) cyc();
        @(negedge clk);
        check("s5_count_drained", {29'd0, count}, 32'd0);
        src_two = 5'd0;

        // reset with pending entries and a simultaneous push/pop
        rf_ready = 1'b0;
        offer(5'd20, 32'h2000); offer(5'd21, 32'h2100); offer(5'd22, 32'h2200);
        @(negedge clk);
        check("s6_count_pre", {29'd0, count}, 32'd3);
        reset = 1'b0; in_valid = 1'b1; in_dest = 5'd23; in_data = 32'h2300; rf_ready = 1'b1;
        cyc();
        reset = 1'b1; in_valid = 1'b0; rf_ready = 1'b0;
        @(negedge clk);
        check("s6_count", {29'd0, count}, 32'd0);
        check("s6_we", {31'd0, write_enable}, 32'd0);
        check("s6_in_ready", {31'd0, in_ready}, 32'd1);

        cyc(); cyc();
        check("final_queue_empty", exp_q.size(), 32'd0);
        check("final_drain_total", drains, 32'd16);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
